joypad_port_multi: RTL and testbench
====================================

Name: joypad_port_multi

Overview:
- Next-generation NES controller port at $4016/$4017, replacing the fixed two-pad 8-bit joystick logic.
- Parametrised pad width and optional Four Score (4-pad multitap) mode.
- Adds real strobe semantics: continuous reload while strobe=1, latch on 1->0.
- Adds a per-port read counter with signature and fill bits after the report ends.
- Sits on the CPU IO-register bus and is fed by any joystick reader through a show-ahead FIFO.

Parameters:
- PAD_BITS, 8: bits per pad report, shifted out MSB first; bit7 = A when 8.
- FOUR_SCORE, 0: 1 = four pads; legal only with PAD_BITS=8.
- FILL_BIT, 1'b1: value returned once a port's sequence is exhausted.
- PORT0_ADDR, 5'h16: ioreg_addr of port 0; strobe write address.
- PORT1_ADDR, 5'h17: ioreg_addr of port 1.

Ports:
- sysclk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_clock  in  1  CPU-cycle enable; an access counts only in a sysclk cycle with joy_cs && cpu_clock.
- joy_cs  in  1  IO-register block select.
- ioreg_addr  in  5  register address.
- ioreg_datain  in  8  CPU write data; bit0 = strobe.
- ioreg_wr  in  1  1 = write, 0 = read.
- ioreg_dataout  out  1  serial bit (CPU D0); 0 when not reading this block.
- strobe_out  out  1  current strobe level, for external readers.
- fifo_empty  in  1  reader FIFO empty.
- fifo_rdreq  out  1  FIFO pop.
- fifo_q  in  NPADS*PAD_BITS  pad states, pad k at [k*PAD_BITS +: PAD_BITS]; NPADS = FOUR_SCORE ? 4 : 2.

Behaviour:
- Access = sysclk cycle with joy_cs && cpu_clock && addr in {PORT0_ADDR, PORT1_ADDR}.
- Reset values: strobe 0, pad_buf 0, snapshots 0, counters 0, fifo_rdreq 0, ioreg_dataout 0.

- FIFO: fifo_rdreq = ~fifo_empty when out of reset.
  - On a pop cycle, pad_buf <= fifo_q (show-ahead) at the next edge; pad_buf holds otherwise.
- Strobe register:
  - Write to PORT0_ADDR: strobe <= ioreg_datain[0].
  - Write to PORT1_ADDR is the APU frame counter's register: ignored, no state change.
- While strobe=1 (registered):
  - Every cycle, snapshot <= pad_buf for all pads and both counters <= 0.
  - Reads return the first bit of the current snapshot without advancing.
- Strobe 1->0: the snapshot from the last strobe=1 cycle is frozen.
  - Single-cycle strobe pulse (write 1 then 0) yields a valid latch.
- Port sequence, p in {0,1}, read MSB first:
  - FOUR_SCORE=0: pad p (PAD_BITS bits), then FILL_BIT forever.
  - FOUR_SCORE=1, 24 bits: pad p, then pad p+2, then signature (port0 SIG0=8'b0001_0000, port1 SIG1=8'b0010_0000), then FILL_BIT.
- Read of port p with strobe=0:
  - ioreg_dataout = seq_p[count_p], combinational within the same cycle.
  - count_p increments at cycle end, saturating at SEQ_LEN; reading is idempotent once saturated.
  - The other port's counter is untouched.
- ioreg_dataout = 0 unless joy_cs && ~ioreg_wr && addr matches either port; cpu_clock is not required for data.
- FIFO pop and strobe reload in the same cycle: snapshot takes the old pad_buf. Pad change to visible snapshot = 2 cycles.
- Reset mid-sequence: counters 0, strobe 0; the next read returns bit 0 of an all-zero snapshot.
- No simultaneous read/write: ioreg_wr selects exactly one.

Decomposition:
- Package joypad_pkg holds:
  - default port addresses;
  - SIG0/SIG1;
  - SEQ_LEN function of (PAD_BITS, FOUR_SCORE);
  - counter width, $clog2(SEQ_LEN+1).
- Sub-module joypad_serializer, instantiated once per port, holds:
  - snapshot registers;
  - saturating counter;
  - sequence mux.
- Top level holds strobe, pad_buf, FIFO handshake and address decode.

Test Plan:
- Default params; push fifo_q=16'hA55A; strobe 1 then 0; 10 reads of $4016 -> 0,1,0,1,1,0,1,0,1,1. Then 8 reads of $4017 -> 1,0,1,0,0,1,0,1.
- Strobe held 1; change fifo_q from 16'h0080 to 16'h0000 mid-way; read $4016 three times -> 1,1,1, then 0 two cycles after the pop; counter stays 0.
- FOUR_SCORE=1; pads = 8'h01, 8'h02, 8'h80, 8'h40; latch; 26 reads of $4016:
  - reads 1-8 -> bit8=1 only;
  - reads 9-16 -> bit9=1 only (pad2=8'h80);
  - reads 17-24 -> signature, read 20=1;
  - reads 25-26 -> 1.
- FOUR_SCORE=1; 24 reads of $4017 -> pad1, pad3, signature with read 19=1.
- Write 8'h00 to $4017; no strobe change, counters intact. Read with joy_cs=0 -> dataout 0.
- Assert reset after 3 reads -> all regs 0, fifo_rdreq 0. Release with fifo non-empty -> rdreq=1; next latch and read gives fresh data from bit 0.

Source files
------------

// File: rtl/joypad_pkg.sv
// joypad_pkg: shared constants and sizing helpers for the multi-pad controller port.
package joypad_pkg;
  localparam logic [4:0] PORT0_ADDR_DEF = 5'h16;
  localparam logic [4:0] PORT1_ADDR_DEF = 5'h17;
  localparam logic [7:0] SIG0 = 8'b0001_0000;
  localparam logic [7:0] SIG1 = 8'b0010_0000;
  // Four Score appends an 8-bit signature after the two pads of a port.
  function automatic int seq_len(input int pad_bits, input bit four_score);
    return four_score ? 2 * pad_bits + 8 : pad_bits;
  endfunction
  function automatic int cnt_w(input int pad_bits, input bit four_score);
    return $clog2(seq_len(pad_bits, four_score) + 1);
  endfunction
endpackage

// File: rtl/joypad_serializer.sv
// joypad_serializer: per-port snapshot, saturating read counter and MSB-first sequence mux.
module joypad_serializer import joypad_pkg::*; #(
  parameter int PAD_BITS = 8,
  parameter bit FOUR_SCORE = 1'b0,
  parameter logic FILL_BIT = 1'b1,
  parameter logic [7:0] SIG = SIG0,
  localparam int SNAP_W = (FOUR_SCORE ? 2 : 1) * PAD_BITS,
  localparam int SEQ_LEN = seq_len(PAD_BITS, FOUR_SCORE),
  localparam int CW = cnt_w(PAD_BITS, FOUR_SCORE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strobe_i,
  input  logic              rd_i,
  input  logic [SNAP_W-1:0] pads_i,
  output logic              bit_o
);
  localparam int SIG_SH = FOUR_SCORE ? 0 : 8;
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SEQ_LEN-1:0] seq, seq_sh;
  // Without Four Score the signature is shifted out of the sequence entirely.
  assign seq = SEQ_LEN'({snap_q, SIG} >> SIG_SH);
  assign seq_sh = seq << cnt_q;
  always_comb begin
    snap_d = strobe_i ? pads_i : snap_q;
    cnt_d = strobe_i ? '0 : (rd_i && cnt_q != CW'(SEQ_LEN)) ? cnt_q + CW'(1) : cnt_q;
    bit_o = strobe_i ? seq[SEQ_LEN-1] : (cnt_q == CW'(SEQ_LEN)) ? FILL_BIT : seq_sh[SEQ_LEN-1];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      snap_q <= '0;
      cnt_q <= '0;
    end else begin
      snap_q <= snap_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/joypad_port_multi.sv
// joypad_port_multi: $4016/$4017 controller port with strobe, FIFO-fed pad buffer and optional Four Score.
module joypad_port_multi import joypad_pkg::*; #(
  parameter int PAD_BITS = 8,
  parameter bit FOUR_SCORE = 1'b0,
  parameter logic FILL_BIT = 1'b1,
  parameter logic [4:0] PORT0_ADDR = PORT0_ADDR_DEF,
  parameter logic [4:0] PORT1_ADDR = PORT1_ADDR_DEF,
  localparam int NPADS = FOUR_SCORE ? 4 : 2
) (
  input  logic                      sysclk,
  input  logic                      reset,
  input  logic                      cpu_clock,
  input  logic                      joy_cs,
  input  logic [4:0]                ioreg_addr,
  input  logic [7:0]                ioreg_datain,
  input  logic                      ioreg_wr,
  output logic                      ioreg_dataout,
  output logic                      strobe_out,
  input  logic                      fifo_empty,
  output logic                      fifo_rdreq,
  input  logic [NPADS*PAD_BITS-1:0] fifo_q
);
  logic strobe_q, strobe_d;
  logic [NPADS*PAD_BITS-1:0] pad_buf_q, pad_buf_d;
  logic [1:0] hit, bits;
  logic acc;
  logic unused_datain;
  assign unused_datain = ^ioreg_datain[7:1];
  always_comb begin
    hit = {ioreg_addr == PORT1_ADDR, ioreg_addr == PORT0_ADDR};
    acc = joy_cs && cpu_clock;
    fifo_rdreq = ~reset & ~fifo_empty;
    // Writes to the port-1 address belong to the APU frame counter.
    strobe_d = (acc && ioreg_wr && hit[0]) ? ioreg_datain[0] : strobe_q;
    pad_buf_d = fifo_rdreq ? fifo_q : pad_buf_q;
    ioreg_dataout = joy_cs && !ioreg_wr && |(hit & bits);
  end
  assign strobe_out = strobe_q;
  always_ff @(posedge sysclk or posedge reset)
    if (reset) begin
      strobe_q <= 1'b0;
      pad_buf_q <= '0;
    end else begin
      strobe_q <= strobe_d;
      pad_buf_q <= pad_buf_d;
    end
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [(FOUR_SCORE ? 2 : 1)*PAD_BITS-1:0] pads;
    if (FOUR_SCORE) begin : g_fs
      assign pads = {pad_buf_q[p*PAD_BITS +: PAD_BITS], pad_buf_q[(p+2)*PAD_BITS +: PAD_BITS]};
    end else begin : g_std
      assign pads = pad_buf_q[p*PAD_BITS +: PAD_BITS];
    end
    joypad_serializer #(
      .PAD_BITS(PAD_BITS),
      .FOUR_SCORE(FOUR_SCORE),
      .FILL_BIT(FILL_BIT),
      .SIG(p == 0 ? SIG0 : SIG1)
    ) u_ser (
      .clk(sysclk),
      .rst(reset),
      .strobe_i(strobe_q),
      .rd_i(acc && !ioreg_wr && hit[p]),
      .pads_i(pads),
      .bit_o(bits[p])
    );
  end
endmodule

// File: tb/tb_joypad_port_multi.sv
// tb_joypad_port_multi: directed checks of a two-pad and a Four Score port sharing one CPU bus.
module tb_joypad_port_multi;
  logic sysclk = 1'b0, reset = 1'b1, cpu_clock = 1'b0, joy_cs = 1'b0, ioreg_wr = 1'b0, fifo_empty = 1'b0;
  logic [4:0] ioreg_addr = 5'h0;
  logic [7:0] ioreg_datain = 8'h0;
  logic [15:0] fifo_q_a = 16'hA55A;
  logic [31:0] fifo_q_b = 32'h4080_0201;
  logic dout_a, dout_b, strobe_a, strobe_b, rdreq_a, rdreq_b;
  int checks = 0, failures = 0;
  logic [9:0] e_std0 = 10'b0101101011;
  logic [7:0] e_std1 = 8'b10100101;
  logic [25:0] e_fs0 = 26'b00000001_10000000_00010000_11;
  logic [23:0] e_fs1 = 24'b00000010_01000000_00100000;
  logic [8:0] e_rst = 9'b000000001;
  logic [7:0] e_c3 = 8'hC3;

  always #5 sysclk = ~sysclk;

  joypad_port_multi dut_a (
    .sysclk(sysclk), .reset(reset), .cpu_clock(cpu_clock), .joy_cs(joy_cs),
    .ioreg_addr(ioreg_addr), .ioreg_datain(ioreg_datain), .ioreg_wr(ioreg_wr),
    .ioreg_dataout(dout_a), .strobe_out(strobe_a), .fifo_empty(fifo_empty),
    .fifo_rdreq(rdreq_a), .fifo_q(fifo_q_a)
  );

  joypad_port_multi #(.FOUR_SCORE(1'b1)) dut_b (
    .sysclk(sysclk), .reset(reset), .cpu_clock(cpu_clock), .joy_cs(joy_cs),
    .ioreg_addr(ioreg_addr), .ioreg_datain(ioreg_datain), .ioreg_wr(ioreg_wr),
    .ioreg_dataout(dout_b), .strobe_out(strobe_b), .fifo_empty(fifo_empty),
    .fifo_rdreq(rdreq_b), .fifo_q(fifo_q_b)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic idle();
    joy_cs = 1'b0;
    cpu_clock = 1'b0;
    ioreg_wr = 1'b0;
  endtask

  task automatic cycle(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    joy_cs = 1'b1; cpu_clock = 1'b1; ioreg_wr = 1'b1; ioreg_addr = a; ioreg_datain = d;
    @(posedge sysclk);
    #1 idle();
  endtask

  task automatic rd(input logic [4:0] a, input bit fs, input logic exp, input string tag);
    joy_cs = 1'b1; cpu_clock = 1'b1; ioreg_wr = 1'b0; ioreg_addr = a;
    @(negedge sysclk);
    chk(tag, fs ? dout_b : dout_a, exp);
    @(posedge sysclk);
    #1 idle();
  endtask

  initial begin
    #2;
    chk("rst_rdreq_a", rdreq_a, 1'b0);
    chk("rst_rdreq_b", rdreq_b, 1'b0);
    chk("rst_strobe", strobe_a, 1'b0);
    joy_cs = 1'b1; ioreg_addr = 5'h16;
    #1 chk("rst_dout", dout_a, 1'b0);
    idle();
    @(posedge sysclk);
    #1 reset = 1'b0;
    #1 chk("rdreq_after_rst", rdreq_a, 1'b1);
    wr(5'h16, 8'h01);
    chk("strobe_hi", strobe_a, 1'b1);
    wr(5'h16, 8'h00);
    chk("strobe_lo", strobe_a, 1'b0);
    for (int i = 0; i < 10; i++) rd(5'h16, 1'b0, e_std0[9-i], $sformatf("std_p0_r%0d", i + 1));
    for (int i = 0; i < 8; i++) rd(5'h17, 1'b0, e_std1[7-i], $sformatf("std_p1_r%0d", i + 1));

    fifo_q_a = 16'h0080;
    cycle(1);
    wr(5'h16, 8'h01);
    cycle(1);
    for (int i = 0; i < 3; i++) rd(5'h16, 1'b0, 1'b1, $sformatf("strb_r%0d", i + 1));
    fifo_q_a = 16'h0000;
    rd(5'h16, 1'b0, 1'b1, "strb_pop_c1");
    rd(5'h16, 1'b0, 1'b1, "strb_pop_c2");
    rd(5'h16, 1'b0, 1'b0, "strb_pop_c3");
    fifo_q_a = 16'h0080;
    cycle(2);
    wr(5'h16, 8'h00);
    rd(5'h16, 1'b0, 1'b1, "strb_cnt0_r1");
    rd(5'h16, 1'b0, 1'b0, "strb_cnt0_r2");

    wr(5'h16, 8'h01);
    wr(5'h16, 8'h00);
    for (int i = 0; i < 26; i++) rd(5'h16, 1'b1, e_fs0[25-i], $sformatf("fs_p0_r%0d", i + 1));
    for (int i = 0; i < 24; i++) rd(5'h17, 1'b1, e_fs1[23-i], $sformatf("fs_p1_r%0d", i + 1));

    fifo_q_a = 16'hA55A;
    cycle(1);
    wr(5'h16, 8'h01);
    wr(5'h16, 8'h00);
    for (int i = 0; i < 4; i++) rd(5'h16, 1'b0, e_std0[9-i], $sformatf("w17_pre_r%0d", i + 1));
    wr(5'h17, 8'h01);
    chk("w17_strobe", strobe_a, 1'b0);
    ioreg_addr = 5'h16; ioreg_wr = 1'b0; cpu_clock = 1'b1; joy_cs = 1'b0;
    @(negedge sysclk);
    chk("cs0_dout", dout_a, 1'b0);
    @(posedge sysclk);
    #1 idle();
    rd(5'h16, 1'b0, 1'b1, "w17_post_r5");
    rd(5'h16, 1'b0, 1'b0, "w17_post_r6");
    rd(5'h17, 1'b0, 1'b1, "p1_indep_r1");
    rd(5'h16, 1'b0, 1'b1, "w17_post_r7");

    wr(5'h16, 8'h01);
    wr(5'h16, 8'h00);
    for (int i = 0; i < 3; i++) rd(5'h16, 1'b0, e_std0[9-i], $sformatf("mid_r%0d", i + 1));
    fifo_q_a = 16'h00C3;
    reset = 1'b1;
    #1;
    chk("mid_rst_strobe", strobe_a, 1'b0);
    chk("mid_rst_rdreq", rdreq_a, 1'b0);
    joy_cs = 1'b1; ioreg_addr = 5'h16;
    #1 chk("mid_rst_dout", dout_a, 1'b0);
    idle();
    @(posedge sysclk);
    #1 reset = 1'b0;
    #1 chk("rel_rdreq", rdreq_a, 1'b1);
    for (int i = 0; i < 9; i++) rd(5'h16, 1'b0, e_rst[8-i], $sformatf("post_rst_r%0d", i + 1));
    wr(5'h16, 8'h01);
    wr(5'h16, 8'h00);
    for (int i = 0; i < 8; i++) rd(5'h16, 1'b0, e_c3[7-i], $sformatf("fresh_r%0d", i + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
